// File: rtl/sprite_overlay_pkg.sv
// Shared types, sprite bitmap and helpers for the sprite overlay layer.
// SPRITE_OVERLAY_SHADOW_EN in the top enables the drop shadow.
package sprite_overlay_pkg;

  localparam int SPR_SIZE   = 16;
  localparam int SHADOW_OFS = 2;

  typedef logic [23:0] rgb_t;
  typedef logic [15:0] sprite_row_t;

  typedef enum logic {
    DIR_POS,
    DIR_NEG
  } dir_t;

  // Row 0 is the top line; bit 15 is the leftmost pixel.
  localparam sprite_row_t SPRITE_BITMAP [SPR_SIZE] = '{
    16'h8001, 16'h07E0, 16'h1FF8, 16'h3FFC,
    16'h7E7E, 16'h7C3E, 16'hF81F, 16'hF00F,
    16'hF00F, 16'hF81F, 16'h7C3E, 16'h7E7E,
    16'h3FFC, 16'h1FF8, 16'h07E0, 16'h8001
  };

  function automatic rgb_t half_rgb(input rgb_t c);
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
  endfunction

endpackage

// File: rtl/sprite_overlay_raster.sv
// Free-running raster counter: x wraps at WIDTH-1, then y steps.
// last_pixel flags the final pixel of each frame.
module raster_counter #(
  parameter int WIDTH  = 400,
  parameter int HEIGHT = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [$clog2(WIDTH)-1:0]  x,
  output logic [$clog2(HEIGHT)-1:0] y,
  output logic                      last_pixel
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic x_last;
  logic y_last;

  assign x_last     = (x == XW'(WIDTH - 1));
  assign y_last     = (y == YW'(HEIGHT - 1));
  assign last_pixel = x_last && y_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (x_last) begin
      x <= '0;
      y <= y_last ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_overlay.sv
// Composites a bouncing 16x16 1bpp sprite over the starfield stream.
// Define SPRITE_OVERLAY_SHADOW_EN for a (+2,+2) half-brightness shadow.
module sprite_overlay
  import sprite_overlay_pkg::*;
#(
  parameter int   WIDTH   = 400,
  parameter int   HEIGHT  = 512,
  parameter int   SPEED   = 2,
  parameter int   INIT_X  = 0,
  parameter int   INIT_Y  = 0,
  parameter rgb_t SPR_RGB = 24'hFFC000
) (
  input  logic        pixel_clock,
  input  logic        reset_n,
  input  logic [23:0] bg_rgb,
  input  logic        motion_en,
  output logic [23:0] pixel_rgb,
  output logic        sprite_hit,
  output logic        frame_end
);

  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;

  localparam logic [XW:0] X_LIM = XW1'(WIDTH - SPR_SIZE);
  localparam logic [YW:0] Y_LIM = YW1'(HEIGHT - SPR_SIZE);
  localparam logic [XW:0] X_SPD = XW1'(SPEED);
  localparam logic [YW:0] Y_SPD = YW1'(SPEED);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          last_pixel;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk        (pixel_clock),
    .rst_n      (reset_n),
    .x          (x),
    .y          (y),
    .last_pixel (last_pixel)
  );

  logic [XW-1:0] pos_x, nxt_x;
  logic [YW-1:0] pos_y, nxt_y;
  dir_t          dir_x, nxt_dx;
  dir_t          dir_y, nxt_dy;

  // One guard bit keeps left/above-the-sprite offsets well out of range.
  logic [XW:0] rx;
  logic [YW:0] ry;
  logic        in_box;
  logic        fg;
  rgb_t        pix_next;

  assign rx     = {1'b0, x} - {1'b0, pos_x};
  assign ry     = {1'b0, y} - {1'b0, pos_y};
  assign in_box = (rx < XW1'(SPR_SIZE)) && (ry < YW1'(SPR_SIZE));
  assign fg     = in_box && SPRITE_BITMAP[ry[3:0]][4'd15 - rx[3:0]];

`ifdef SPRITE_OVERLAY_SHADOW_EN
  logic [XW:0] sx;
  logic [YW:0] sy;
  logic        sh_box;
  logic        shadow;

  assign sx     = rx - XW1'(SHADOW_OFS);
  assign sy     = ry - YW1'(SHADOW_OFS);
  assign sh_box = (sx < XW1'(SPR_SIZE)) && (sy < YW1'(SPR_SIZE));
  assign shadow = !fg && sh_box
                && SPRITE_BITMAP[sy[3:0]][4'd15 - sx[3:0]];

  always_comb begin
    pix_next = bg_rgb;
    unique case (1'b1)
      fg:      pix_next = SPR_RGB;
      shadow:  pix_next = half_rgb(bg_rgb);
      default: pix_next = bg_rgb;
    endcase
  end
`else
  assign pix_next = fg ? SPR_RGB : bg_rgb;
`endif

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_rgb  <= '0;
      sprite_hit <= 1'b0;
      frame_end  <= 1'b0;
    end else begin
      pixel_rgb  <= pix_next;
      sprite_hit <= fg;
      frame_end  <= last_pixel;
    end
  end

  logic [XW:0] x_sum;
  logic [YW:0] y_sum;

  assign x_sum = {1'b0, pos_x} + X_SPD;
  assign y_sum = {1'b0, pos_y} + Y_SPD;

  // Position only moves on the last pixel so the next frame starts clean.
  always_comb begin
    nxt_x  = pos_x;
    nxt_y  = pos_y;
    nxt_dx = dir_x;
    nxt_dy = dir_y;
    if (last_pixel && motion_en) begin
      case (dir_x)
        DIR_POS: begin
          if (x_sum >= X_LIM) begin
            nxt_x  = X_LIM[XW-1:0];
            nxt_dx = DIR_NEG;
          end else begin
            nxt_x = x_sum[XW-1:0];
          end
        end
        default: begin
          if ({1'b0, pos_x} <= X_SPD) begin
            nxt_x  = '0;
            nxt_dx = DIR_POS;
          end else begin
            nxt_x = pos_x - X_SPD[XW-1:0];
          end
        end
      endcase
      case (dir_y)
        DIR_POS: begin
          if (y_sum >= Y_LIM) begin
            nxt_y  = Y_LIM[YW-1:0];
            nxt_dy = DIR_NEG;
          end else begin
            nxt_y = y_sum[YW-1:0];
          end
        end
        default: begin
          if ({1'b0, pos_y} <= Y_SPD) begin
            nxt_y  = '0;
            nxt_dy = DIR_POS;
          end else begin
            nxt_y = pos_y - Y_SPD[YW-1:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      pos_x <= XW'(INIT_X);
      pos_y <= YW'(INIT_Y);
      dir_x <= DIR_POS;
      dir_y <= DIR_POS;
    end else begin
      pos_x <= nxt_x;
      pos_y <= nxt_y;
      dir_x <= nxt_dx;
      dir_y <= nxt_dy;
    end
  end

endmodule

// File: tb/tb_sprite_overlay.sv
// Random-stimulus bench for sprite_overlay against a pixel-level model.
// Small raster so many bounces and frames fit in a short run.
module tb_sprite_overlay;

  localparam int W      = 40;
  localparam int H      = 20;
  localparam int SPD    = 3;
  localparam int IX     = 23;
  localparam int IY     = 1;
  localparam int FRAME  = W * H;
  localparam int N_CYC  = 18 * FRAME;
  localparam int RST_AT = 9 * FRAME + 7 * W + 13;
  localparam logic [23:0] SPR = 24'hFFC000;

  localparam logic [15:0] BMP [16] = '{
    16'h8001, 16'h07E0, 16'h1FF8, 16'h3FFC,
    16'h7E7E, 16'h7C3E, 16'hF81F, 16'hF00F,
    16'hF00F, 16'hF81F, 16'h7C3E, 16'h7E7E,
    16'h3FFC, 16'h1FF8, 16'h07E0, 16'h8001
  };

  logic        pixel_clock;
  logic        reset_n;
  logic [23:0] bg_rgb;
  logic        motion_en;
  logic [23:0] pixel_rgb;
  logic        sprite_hit;
  logic        frame_end;

  sprite_overlay #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .SPEED   (SPD),
    .INIT_X  (IX),
    .INIT_Y  (IY),
    .SPR_RGB (SPR)
  ) dut (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .bg_rgb      (bg_rgb),
    .motion_en   (motion_en),
    .pixel_rgb   (pixel_rgb),
    .sprite_hit  (sprite_hit),
    .frame_end   (frame_end)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  int mx, my, px, py, dx, dy;
  int fe_seen, fe_exp;
  logic [23:0] e_rgb;
  logic        e_hit;
  logic        e_fe;

  function automatic logic bit_at(input int r, input int c);
    if (r < 0 || r > 15 || c < 0 || c > 15) return 1'b0;
    return BMP[r][15-c];
  endfunction

  task automatic move(inout int p, inout int d, input int lim);
    if (d > 0) begin
      if (p + SPD >= lim - 16) begin
        p = lim - 16;
        d = -1;
      end else begin
        p = p + SPD;
      end
    end else if (p <= SPD) begin
      p = 0;
      d = 1;
    end else begin
      p = p - SPD;
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0;
    px = IX; py = IY;
    dx = 1; dy = 1;
    e_rgb = '0; e_hit = 1'b0; e_fe = 1'b0;
  endtask

  // Expected output for the pixel presented this cycle, then advance.
  task automatic model_step();
    logic fg, sh;
    fg = bit_at(my - py, mx - px);
    sh = 1'b0;
`ifdef SPRITE_OVERLAY_SHADOW_EN
    sh = !fg && bit_at(my - py - 2, mx - px - 2);
`endif
    if (fg) e_rgb = SPR;
    else if (sh) e_rgb = {bg_rgb[23:16] >> 1, bg_rgb[15:8] >> 1,
                          bg_rgb[7:0] >> 1};
    else e_rgb = bg_rgb;
    e_hit = fg;
    e_fe  = (mx == W - 1) && (my == H - 1);
    if (e_fe) fe_exp++;
    if (e_fe && motion_en) begin
      move(px, dx, W);
      move(py, dy, H);
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    bg_rgb    = 24'h101010;
    motion_en = 1'b0;
    fe_seen   = 0;
    fe_exp    = 0;
    model_reset();
    repeat (3) @(negedge pixel_clock);
    reset_n = 1'b1;
    for (int c = 0; c < N_CYC && errors < 20; c++) begin
      if (c == RST_AT) begin
        #2 reset_n = 1'b0;
        #1;
        check("async_rgb", 32'(pixel_rgb), 32'h0);
        check("async_hit", 32'(sprite_hit), 32'h0);
        check("async_fe", 32'(frame_end), 32'h0);
        @(negedge pixel_clock);
        reset_n = 1'b1;
        model_reset();
      end
      check("rgb", 32'(pixel_rgb), 32'(e_rgb));
      check("hit", 32'(sprite_hit), 32'(e_hit));
      check("frame_end", 32'(frame_end), 32'(e_fe));
      if (frame_end) fe_seen++;
      if (c < 3 * FRAME) begin
        bg_rgb    = 24'h101010;
        motion_en = 1'b1;
      end else begin
        bg_rgb    = ($urandom_range(0, 3) == 0) ? 24'h808080
                                                : 24'($urandom);
        motion_en = ($urandom_range(0, 3) != 0);
      end
      model_step();
      @(negedge pixel_clock);
    end
    check("frame_count", 32'(fe_seen), 32'(fe_exp - (e_fe ? 1 : 0)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
